// File: rtl/udp_tx_buf.sv
// Ping-pong transmit buffer between a byte producer and a UDP sender.
// The writer fills one bank while the reader hands the other, closed bank to
// the sender through a start/busy/idle handshake.
module udp_tx_buf #(
  parameter int MAX_LEN = 1472,
  parameter int ADDR_W  = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_wr_data,
  input  logic        i_wr,
  input  logic        i_flush,
  output logic        o_full,
  output logic        o_overflow,
  output logic [7:0]  o_data,
  input  logic        i_rd,
  output logic [15:0] o_data_len,
  output logic        o_enable,
  input  logic        i_ready
);
  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [15:0] LEN_MAX = 16'(MAX_LEN);

  typedef enum logic [1:0] {R_IDLE, R_START, R_WAIT_BUSY, R_SEND} rd_state_t;

  // Both banks share one array; the bank select is the address MSB.
  logic [7:0]       mem [2*DEPTH];
  logic [1:0]       full;
  logic [1:0][15:0] len;
  logic             wr_bank, rd_bank, rd_bank_n;
  logic [15:0]      rd_ptr, rd_ptr_n;
  rd_state_t        state, state_n;
  logic [15:0]      wr_len, wr_len_n;
  logic             wr_acc, wr_close, wr_switch, other_free;
  logic             rd_start, rd_rel;

  // Write side decisions; the write pointer is the open bank's length.
  always_comb begin
    wr_len     = len[wr_bank];
    wr_acc     = i_wr && !full[wr_bank];
    wr_len_n   = wr_len + 16'(wr_acc);
    // A byte written together with a flush is part of the closed packet.
    wr_close   = !full[wr_bank] &&
                 ((wr_len_n == LEN_MAX) || (i_flush && (wr_len_n != 16'd0)));
    // A release in this cycle frees the other bank before the writer looks at it.
    other_free = !full[~wr_bank] || (rd_rel && (rd_bank != wr_bank));
    // Switch on close, or when a stalled writer sees the other bank released.
    wr_switch  = (wr_close || full[wr_bank]) && other_free;
  end

  assign o_full = full[wr_bank];

  // Payload storage, written only through the open bank.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[{wr_bank, wr_len[ADDR_W-1:0]}] <= i_wr_data;
  end

  // Bank full flags, lengths, writer bank select and the drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full       <= '0;
      len        <= '0;
      wr_bank    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= i_wr && full[wr_bank];
      if (rd_rel)   full[rd_bank] <= 1'b0;
      if (wr_acc)   len[wr_bank]  <= wr_len_n;
      if (wr_close) full[wr_bank] <= 1'b1;
      if (wr_switch) begin
        wr_bank       <= ~wr_bank;
        len[~wr_bank] <= '0;
      end
    end
  end

  // Reader FSM next state, pointer advance and sender start strobe.
  always_comb begin
    state_n   = state;
    rd_ptr_n  = rd_ptr;
    rd_bank_n = rd_bank;
    rd_start  = 1'b0;
    rd_rel    = 1'b0;
    o_enable  = 1'b0;
    case (state)
      R_IDLE: begin
        if (full[rd_bank] && i_ready) begin
          state_n  = R_START;
          rd_start = 1'b1;
          rd_ptr_n = '0;
        end
      end
      R_START: begin
        o_enable = 1'b1;
        state_n  = R_WAIT_BUSY;
      end
      R_WAIT_BUSY: begin
        if (!i_ready) state_n = R_SEND;
      end
      R_SEND: begin
        // The pointer stops at the packet length; extra strobes do nothing.
        if (i_rd && (rd_ptr != o_data_len)) rd_ptr_n = rd_ptr + 16'd1;
        if (i_ready) begin
          state_n   = R_IDLE;
          rd_rel    = 1'b1;
          rd_bank_n = ~rd_bank;
        end
      end
      default: state_n = R_IDLE;
    endcase
  end

  // Reader registers; o_data is a registered read at the next pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= R_IDLE;
      rd_bank    <= 1'b0;
      rd_ptr     <= '0;
      o_data_len <= '0;
      o_data     <= '0;
    end else begin
      state   <= state_n;
      rd_bank <= rd_bank_n;
      rd_ptr  <= rd_ptr_n;
      if (rd_start) o_data_len <= len[rd_bank];
      o_data  <= mem[{rd_bank_n, rd_ptr_n[ADDR_W-1:0]}];
    end
  end

endmodule

// File: doc/udp_tx_buf.md
UDP_TX_BUF -- requirements
Module: udp_tx_buf

Interface
REQ-001 Parameter MAX_LEN, default 1472, payload bytes per packet at which a bank auto-closes (1..2^ADDR_W).
REQ-002 Parameter ADDR_W, default 11, bank address width; each bank holds 2^ADDR_W bytes.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_wr_data  input  8  payload byte from producer.
REQ-006 i_wr  input  1  write strobe; byte accepted when i_wr=1 and o_full=0.
REQ-007 i_flush  input  1  close the current bank early (send a short packet).
REQ-008 o_full  output  1  no writable bank; writes are dropped.
REQ-009 o_overflow  output  1  one-cycle pulse per dropped write.
REQ-010 o_data  output  8  current payload byte to the UDP sender.
REQ-011 i_rd  input  1  sender byte-advance strobe.
REQ-012 o_data_len  output  16  payload length of the bank being sent.
REQ-013 o_enable  output  1  start request to the sender.
REQ-014 i_ready  input  1  sender idle indication.

Function
REQ-015 Two banks (ping-pong), each with a 16-bit length register and a full flag; the writer fills one bank while the reader drains the other.
REQ-016 Accepted write stores the byte at wr_ptr of the write bank and increments wr_ptr and that bank's length.
REQ-017 Write bank closes (full flag set, length frozen) on the cycle its length reaches MAX_LEN, or on i_flush with length>0; i_flush with length 0 is ignored.
REQ-018 Write on the same cycle as i_flush is stored first and counted in the closed length.
REQ-019 After a close, the writer switches to the other bank with wr_ptr=0 if that bank is not full; otherwise o_full=1 until the reader releases it, then the switch happens on the release cycle.
REQ-020 Reader FSM states: R_IDLE, R_START, R_WAIT_BUSY, R_SEND.
REQ-021 R_IDLE -> R_START when the read bank is full and i_ready=1; rd_ptr=0, o_data_len loaded.
REQ-022 R_START: o_enable=1 for exactly one cycle, then -> R_WAIT_BUSY.
REQ-023 R_WAIT_BUSY -> R_SEND when i_ready=0.
REQ-024 R_SEND -> R_IDLE when i_ready returns to 1; on that transition the read bank's full flag is cleared and the reader moves to the other bank.
REQ-025 o_data always shows byte[rd_ptr] of the read bank; on i_rd=1 in R_SEND rd_ptr increments and o_data shows the next byte on the following cycle (memory read address = rd_ptr+1 when i_rd, else rd_ptr, registered).
REQ-026 i_rd outside R_SEND, or when rd_ptr = o_data_len, is ignored; rd_ptr never exceeds o_data_len.
REQ-027 o_data_len holds its value from R_START until the next R_START.
REQ-028 Release and write-bank close in the same cycle: the release is applied first, so the writer switches without asserting o_full.
REQ-029 Banks are served strictly in fill order.
REQ-030 All pointer and length arithmetic is unsigned and saturating at the bank limits; there is no wrap into the other bank.

Reset
REQ-031 On rst_n=0: both full flags, lengths and pointers = 0; writer and reader both on bank 0; FSM = R_IDLE.
REQ-032 On rst_n=0: o_full=0, o_overflow=0, o_enable=0, o_data_len=0, o_data=0.
REQ-033 Reset asserted mid-packet discards all buffered data; no o_enable is issued after reset until a bank closes again.

Verification
REQ-034 Write 1472 bytes 0x00..0xBF (repeating pattern), i_ready=1 -> one-cycle o_enable, o_data_len=1472; sender model reads 1472 bytes matching the written sequence.
REQ-035 Write 5 bytes then i_flush -> o_data_len=5; i_flush with an empty bank -> no o_enable.
REQ-036 Hold i_ready=0 and write 3*MAX_LEN bytes -> o_full=1 after 2*MAX_LEN bytes; o_overflow pulses MAX_LEN times; first two packets are delivered intact.
REQ-037 Extra i_rd beyond o_data_len, and i_rd in R_IDLE -> rd_ptr unchanged, o_data stable.
REQ-038 Writer closes bank 1 on the same cycle the reader releases bank 0 -> o_full stays 0 and packets are sent in order 0, 1.
REQ-039 Assert rst_n=0 during R_SEND -> all outputs take their reset values; after release, a new 10-byte flush yields o_data_len=10.
